prog_loader: RTL and testbench
==============================

# prog_loader

Program loader upstream of the single-cycle RV32 processor. It accepts 32-bit program words over a valid/ready stream and serialises each word into four little-endian byte writes on the processor's `memEn`/`memAddr`/`memData` load port. It holds the processor in reset while loading and releases it once the image is complete. It also flags images that overflow memory.

## Interface
- `WIDTH`, default 32: word, address and data width.
- `MEM_DEPTH`, default 16384: processor memory size in bytes; must be a power of two and a multiple of 4.
- `clock` in 1: the single clock; all state updates on its rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `start` in 1: single-cycle pulse that begins a load.
- `in_valid` in 1: a stream word is presented.
- `in_data` in WIDTH: stream word.
- `in_last` in 1: qualifies the final word of the image.
- `in_ready` out 1: loader accepts a word this cycle.
- `memEn` out 1: byte write strobe to the processor.
- `memAddr` out WIDTH: byte address, always below MEM_DEPTH.
- `memData` out WIDTH: `{24'b0, byte}`.
- `cpu_reset` out 1: active-high; drives the processor `reset`.
- `done` out 1: image loaded and processor released.
- `error` out 1: load aborted.
- `word_count` out $clog2(MEM_DEPTH/4)+1: number of words written in the current load.

## Operation
- States are IDLE, RECV, WRITE, DONE and ERR. All outputs are registered.
- **IDLE**: `cpu_reset`=1. On `start`: clear `word_count` and the byte index, then go to RECV.
- **RECV**: `in_ready`=1. On `in_valid & in_ready`, latch `in_data` and `in_last`, then go to WRITE.
  - If `word_count == MEM_DEPTH/4` when a word is accepted, go to ERR and write nothing.
- **WRITE**: four cycles with `memEn`=1. Byte k (0..3) = `in_data[8k+7:8k]`, written at `memAddr = 4*word_count + k`.
  - After k=3: increment `word_count`.
  - Next state is DONE if the latched `last` is set, otherwise RECV.
- **DONE**: `cpu_reset`=0 and `done`=1, held. `start` re-enters RECV with `cpu_reset`=1 and `done`=0.
- **ERR**: `error`=1 (sticky) and `cpu_reset`=1. `start` clears `error` and re-enters RECV.
- `start` is ignored in RECV and WRITE.
- `in_ready` is 0 in every state except RECV.
- Load base address is fixed at 0, because the processor PC resets to 0.
- `memAddr` upper bits are always zero.

## Timing
- Reset values: `memEn`=0, `memAddr`=0, `memData`=0, `in_ready`=0, `cpu_reset`=1, `done`=0, `error`=0, `word_count`=0, state IDLE.
- `reset_n` low mid-WRITE forces these values immediately, without waiting for a clock edge. A partially written word is not completed.
- A word accepted on edge N produces `memEn` high in cycles N+1..N+4. `in_ready` is high again in cycle N+5.
- Maximum throughput is one word per 5 cycles.
- `cpu_reset` falls and `done` rises one cycle after the last byte strobe.
- `in_valid` may drop at any time; the loader stalls in RECV indefinitely.

## Configuration
- The `PROG_LOADER_CHECKSUM_EN` macro controls checksum handling of the `in_last` word.
- **Defined**:
  - The `in_last` word is a checksum and is not written to memory.
  - The loader keeps a running mod-2^32 sum of every written word.
  - On accepting the `in_last` word, go to DONE if it equals the sum, otherwise ERR.
  - An image consisting of the checksum word alone is valid when it equals 0.
- **Undefined**: the `in_last` word is ordinary program data and is written to memory.

## Structure
- Package `prog_loader_pkg`:
  - state enum `loader_state_t`;
  - `BYTES_PER_WORD = 4`.
- Single module. No sub-module is warranted; the byte serialiser is a 2-bit index inside WRITE.

## Test plan
- **Reset**: hold `reset_n`=0 mid-run -> all outputs at their reset values asynchronously, `cpu_reset`=1.
- **Two-word load**: `start`, then `0x00500093` followed by `0x00000013` with `in_last` -> 8 strobes at addresses 0..7 carrying data 0x93,0x00,0x50,0x00,0x13,0x00,0x00,0x00. Then `done`=1, `cpu_reset`=0, `word_count`=2.
- **Bursty source**: `in_valid` toggled randomly -> `in_ready` is never high outside RECV, no word is lost or duplicated, and memory contents are identical to the two-word load.
- **Overflow** (MEM_DEPTH=16): 5 words, the last flagged `in_last` -> bytes 0..15 written, `error`=1, `cpu_reset`=1, no strobe for word 5.
- **Restart**: `start` in DONE -> `cpu_reset`=1, `word_count`=0, and a new image loads from address 0.
- **Checksum** (macro on): words 1, 2, then 3 with `in_last` -> `done`=1 with 8 strobes. The same image with a final word of 4 -> `error`=1.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: state encoding and word geometry.
// The checksum option (PROG_LOADER_CHECKSUM_EN) is handled in prog_loader.sv.
package prog_loader_pkg;

   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      LS_IDLE  = 3'd0,
      LS_RECV  = 3'd1,
      LS_WRITE = 3'd2,
      LS_DONE  = 3'd3,
      LS_ERR   = 3'd4
   } loader_state_t;

endpackage : prog_loader_pkg

// File: rtl/prog_loader_if.sv
// Stream input plus processor byte-load port of the program loader.
// master = loader side (drives the memory port, consumes the stream); slave = environment side.
interface prog_loader_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             in_ready;
   logic             memEn;
   logic [WIDTH-1:0] memAddr;
   logic [WIDTH-1:0] memData;

   modport master (
      input  in_valid, in_data, in_last,
      output in_ready, memEn, memAddr, memData
   );

   modport slave (
      output in_valid, in_data, in_last,
      input  in_ready, memEn, memAddr, memData
   );
endinterface : prog_loader_if

// File: rtl/prog_loader.sv
// Serialises 32-bit stream words into little-endian byte writes and holds the CPU in reset while loading.
// Define PROG_LOADER_CHECKSUM_EN to treat the in_last word as a checksum of the written image.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int MEM_DEPTH = 16384
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          start,
   prog_loader_if.master                 bus,
   output logic                          cpu_reset,
   output logic                          done,
   output logic                          error,
   output logic [$clog2(MEM_DEPTH/4):0]  word_count
);

   localparam int              WCW       = $clog2(MEM_DEPTH/4) + 1;
   localparam logic [WCW-1:0]  WC_FULL   = WCW'(MEM_DEPTH/4);
   localparam logic [1:0]      LAST_BYTE = 2'(BYTES_PER_WORD - 1);

   localparam logic [2:0] S_IDLE  = LS_IDLE;
   localparam logic [2:0] S_RECV  = LS_RECV;
   localparam logic [2:0] S_WRITE = LS_WRITE;
   localparam logic [2:0] S_DONE  = LS_DONE;
   localparam logic [2:0] S_ERR   = LS_ERR;

   logic [2:0]       state_q,      state_d;
   logic [1:0]       byte_idx_q,   byte_idx_d;
   logic [WIDTH-1:0] word_q,       word_d;
   logic             last_q,       last_d;
   logic [WCW-1:0]   word_count_q, word_count_d;
   logic             mem_en_q,     mem_en_d;
   logic [WIDTH-1:0] mem_addr_q,   mem_addr_d;
   logic [WIDTH-1:0] mem_data_q,   mem_data_d;
   logic             in_ready_q,   in_ready_d;
   logic             cpu_reset_q,  cpu_reset_d;
   logic             done_q,       done_d;
   logic             error_q,      error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [WIDTH-1:0] sum_q,        sum_d;
`endif

   logic [1:0]       byte_nxt;
   logic [WIDTH-1:0] word_base;

   // Word base address comes from the word counter, so the load always starts at 0.
   assign byte_nxt  = byte_idx_q + 2'd1;
   assign word_base = WIDTH'(word_count_q) << 2;

   always_comb begin
      state_d      = state_q;
      byte_idx_d   = byte_idx_q;
      word_d       = word_q;
      last_d       = last_q;
      word_count_d = word_count_q;
      mem_en_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      in_ready_d   = 1'b0;
      cpu_reset_d  = cpu_reset_q;
      done_d       = done_q;
      error_d      = error_q;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_d        = sum_q;
`endif
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d      = S_RECV;
               word_count_d = '0;
               byte_idx_d   = '0;
               in_ready_d   = 1'b1;
               cpu_reset_d  = 1'b1;
               done_d       = 1'b0;
               error_d      = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
               sum_d        = '0;
`endif
            end
         end
         S_RECV: begin
            in_ready_d = 1'b1;
            if (bus.in_valid && in_ready_q) begin
               in_ready_d = 1'b0;
               if (word_count_q == WC_FULL) begin
                  state_d = S_ERR;
                  error_d = 1'b1;
               end
`ifdef PROG_LOADER_CHECKSUM_EN
               else if (bus.in_last) begin
                  // Checksum word is compared, never written.
                  if (bus.in_data == sum_q) begin
                     state_d     = S_DONE;
                     done_d      = 1'b1;
                     cpu_reset_d = 1'b0;
                  end else begin
                     state_d = S_ERR;
                     error_d = 1'b1;
                  end
               end
`endif
               else begin
                  state_d    = S_WRITE;
                  word_d     = bus.in_data;
                  last_d     = bus.in_last;
                  byte_idx_d = '0;
                  mem_en_d   = 1'b1;
                  mem_addr_d = word_base;
                  mem_data_d = WIDTH'(bus.in_data[7:0]);
               end
            end
         end
         S_WRITE: begin
            if (byte_idx_q == LAST_BYTE) begin
               word_count_d = word_count_q + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
               sum_d        = sum_q + word_q;
`endif
               if (last_q) begin
                  state_d     = S_DONE;
                  done_d      = 1'b1;
                  cpu_reset_d = 1'b0;
               end else begin
                  state_d    = S_RECV;
                  in_ready_d = 1'b1;
               end
            end else begin
               byte_idx_d = byte_nxt;
               mem_en_d   = 1'b1;
               mem_addr_d = mem_addr_q + 1'b1;
               mem_data_d = WIDTH'(word_q[{byte_nxt, 3'b000} +: 8]);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         byte_idx_q   <= '0;
         word_q       <= '0;
         last_q       <= 1'b0;
         word_count_q <= '0;
         mem_en_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         in_ready_q   <= 1'b0;
         cpu_reset_q  <= 1'b1;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
         sum_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         byte_idx_q   <= byte_idx_d;
         word_q       <= word_d;
         last_q       <= last_d;
         word_count_q <= word_count_d;
         mem_en_q     <= mem_en_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         in_ready_q   <= in_ready_d;
         cpu_reset_q  <= cpu_reset_d;
         done_q       <= done_d;
         error_q      <= error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
         sum_q        <= sum_d;
`endif
      end
   end

   assign bus.in_ready = in_ready_q;
   assign bus.memEn    = mem_en_q;
   assign bus.memAddr  = mem_addr_q;
   assign bus.memData  = mem_data_q;
   assign cpu_reset    = cpu_reset_q;
   assign done         = done_q;
   assign error        = error_q;
   assign word_count   = word_count_q;

endmodule : prog_loader

// File: tb/tb_prog_loader.sv
// Randomised bench for prog_loader (MEM_DEPTH=16) against an image-level reference model.
// Honours PROG_LOADER_CHECKSUM_EN when the build defines it.
module tb_prog_loader;

   localparam int W     = 32;
   localparam int DEPTH = 16;
   localparam int WPM   = DEPTH / 4;
`ifdef PROG_LOADER_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          widx;
      int          k;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } obs_t;

   logic       clock   = 1'b0;
   logic       reset_n = 1'b0;
   logic       start   = 1'b0;
   logic       cpu_reset;
   logic       done;
   logic       error;
   logic [2:0] word_count;

   prog_loader_if #(.WIDTH(W)) bus();

   prog_loader #(.WIDTH(W), .MEM_DEPTH(DEPTH)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .start      (start),
      .bus        (bus),
      .cpu_reset  (cpu_reset),
      .done       (done),
      .error      (error),
      .word_count (word_count)
   );

   always #5 clock = ~clock;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc      = 0;
   int          viol     = 0;
   bit          term_seen = 1'b0;
   int          term_cyc  = 0;
   obs_t        mon_o;
   obs_t        obs_q[$];
   int          acc_q[$];
   exp_t        exp_q[$];
   logic [31:0] img_w[$];
   bit          img_l[$];
   bit          exp_done, exp_err, term_via_write;
   int          exp_wc, term_widx;
   int          load_no = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Observation on the falling edge: strobes, handshakes, first done/error, in_ready misuse.
   always @(negedge clock) begin
      cyc++;
      if (bus.memEn === 1'b1) begin
         mon_o.addr = bus.memAddr;
         mon_o.data = bus.memData;
         mon_o.cyc  = cyc;
         obs_q.push_back(mon_o);
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) acc_q.push_back(cyc);
      if ((done || error) && !term_seen) begin
         term_seen = 1'b1;
         term_cyc  = cyc;
      end
      if (bus.in_ready && (bus.memEn || done || error || !cpu_reset)) viol++;
   end

   task automatic check_reset_vals(input string p);
      check_val({p, "_memEn"},      bus.memEn,    0);
      check_val({p, "_memAddr"},    bus.memAddr,  0);
      check_val({p, "_memData"},    bus.memData,  0);
      check_val({p, "_in_ready"},   bus.in_ready, 0);
      check_val({p, "_cpu_reset"},  cpu_reset,    1);
      check_val({p, "_done"},       done,         0);
      check_val({p, "_error"},      error,        0);
      check_val({p, "_word_count"}, word_count,   0);
   endtask

   task automatic pulse_start(input string p);
      start = 1'b1;
      @(posedge clock); #1;
      start     = 1'b0;
      term_seen = 1'b0;
      viol      = 0;
      obs_q.delete();
      acc_q.delete();
      check_val({p, "_start_cpu_reset"},  cpu_reset,    1);
      check_val({p, "_start_done"},       done,         0);
      check_val({p, "_start_error"},      error,        0);
      check_val({p, "_start_word_count"}, word_count,   0);
      check_val({p, "_start_in_ready"},   bus.in_ready, 1);
   endtask

   // Reference: walk the image word by word using the loader's rules at image level.
   task automatic build_model();
      logic [31:0] sum;
      exp_t        e;
      exp_q.delete();
      sum            = '0;
      exp_wc         = 0;
      exp_done       = 1'b0;
      exp_err        = 1'b0;
      term_via_write = 1'b0;
      term_widx      = img_w.size() - 1;
      for (int i = 0; i < img_w.size(); i++) begin
         if (exp_wc == WPM) begin
            exp_err   = 1'b1;
            term_widx = i;
            break;
         end
         if (CSUM && img_l[i]) begin
            if (img_w[i] == sum) exp_done = 1'b1;
            else                 exp_err  = 1'b1;
            term_widx = i;
            break;
         end
         for (int k = 0; k < 4; k++) begin
            e.addr = 32'(4 * exp_wc + k);
            e.data = (img_w[i] >> (8 * k)) & 32'hff;
            e.widx = i;
            e.k    = k;
            exp_q.push_back(e);
         end
         exp_wc++;
         sum = sum + img_w[i];
         if (img_l[i]) begin
            exp_done       = 1'b1;
            term_via_write = 1'b1;
            term_widx      = i;
            break;
         end
      end
   endtask

   task automatic drive_image(input bit bursty);
      bit hs;
      int budget;
      for (int i = 0; i < img_w.size(); i++) begin
         hs     = 1'b0;
         budget = 0;
         while (!hs && budget < 200) begin
            bus.in_valid = bursty ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.in_data  = bus.in_valid ? img_w[i] : $urandom;
            bus.in_last  = bus.in_valid ? img_l[i] : 1'($urandom_range(0, 1));
            @(negedge clock);
            hs = bus.in_valid && bus.in_ready;
            @(posedge clock); #1;
            budget++;
         end
         check_val("accept_in_budget", hs, 1);
      end
      bus.in_valid = 1'b0;
      budget = 0;
      while (!term_seen && budget < 50) begin
         @(posedge clock); #1;
         budget++;
      end
      check_val("finish_in_budget", term_seen, 1);
   endtask

   task automatic run_load(input string name, input bit bursty);
      int tc;
      load_no++;
      pulse_start(name);
      drive_image(bursty);
      build_model();
      check_val({name, "_strobes"},  obs_q.size(), exp_q.size());
      check_val({name, "_accepts"},  acc_q.size(), term_widx + 1);
      if (obs_q.size() == exp_q.size() && acc_q.size() == term_widx + 1) begin
         foreach (exp_q[j]) begin
            check_val({name, "_addr"}, obs_q[j].addr, exp_q[j].addr);
            check_val({name, "_data"}, obs_q[j].data, exp_q[j].data);
            check_val({name, "_strobe_cycle"}, obs_q[j].cyc, acc_q[exp_q[j].widx] + 1 + exp_q[j].k);
         end
         tc = term_via_write ? acc_q[term_widx] + 5 : acc_q[term_widx] + 1;
         check_val({name, "_term_cycle"}, term_cyc, tc);
      end
      check_val({name, "_done"},       done,       exp_done);
      check_val({name, "_error"},      error,      exp_err);
      check_val({name, "_cpu_reset"},  cpu_reset,  !exp_done);
      check_val({name, "_word_count"}, word_count, exp_wc);
      check_val({name, "_in_ready_misuse"}, viol,  0);
      $display("load %0d %s: %0d words, %0d strobes, done=%0d error=%0d word_count=%0d",
               load_no, name, img_w.size(), obs_q.size(), done, error, word_count);
   endtask

   task automatic set_image(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2, input int n);
      img_w.delete();
      img_l.delete();
      if (n > 0) begin img_w.push_back(w0); img_l.push_back(n == 1); end
      if (n > 1) begin img_w.push_back(w1); img_l.push_back(n == 2); end
      if (n > 2) begin img_w.push_back(w2); img_l.push_back(1'b1); end
   endtask

   initial begin
      int          budget;
      int          len;
      logic [31:0] s;
      logic [31:0] w;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_last  = 1'b0;

      repeat (2) @(posedge clock);
      #1;
      check_reset_vals("in_reset");
      @(negedge clock); reset_n = 1'b1;
      @(posedge clock); #1;
      check_reset_vals("after_reset");

      set_image(32'h00500093, 32'h00000013, 32'h0, 2);
      run_load("two_word", 1'b0);
      run_load("bursty", 1'b1);

      img_w.delete();
      img_l.delete();
      for (int i = 0; i < 5; i++) begin
         img_w.push_back($urandom);
         img_l.push_back(i == 4);
      end
      run_load("overflow", 1'b0);

      set_image(32'd1, 32'd2, 32'd3, 3);
      run_load("csum_good", 1'b1);
      set_image(32'd1, 32'd2, 32'd4, 3);
      run_load("csum_bad", 1'b0);

      // Asynchronous reset in the middle of a word write.
      pulse_start("midrst");
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      bus.in_last  = 1'b0;
      budget = 0;
      while (bus.memEn !== 1'b1 && budget < 20) begin
         @(negedge clock);
         budget++;
      end
      bus.in_valid = 1'b0;
      check_val("midrst_in_write", bus.memEn, 1);
      #2 reset_n = 1'b0;
      #1 check_reset_vals("midrst_async");
      @(negedge clock); reset_n = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check_reset_vals("midrst_after");

      for (int r = 0; r < 6; r++) begin
         img_w.delete();
         img_l.delete();
         len = $urandom_range(1, 5);
         s   = '0;
         for (int i = 0; i < len; i++) begin
            w = $urandom;
            if (i == len - 1 && $urandom_range(0, 1) == 1) w = s;
            s = s + w;
            img_w.push_back(w);
            img_l.push_back(i == len - 1);
         end
         run_load("random", 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_prog_loader
